// File: rtl/pio_master.sv
// Single-outstanding register-bus initiator: host command -> one-cycle rd/wr strobe
// -> wait for slave ack/rvalid or watchdog expiry -> response held until the host takes it.
module pio_master #(
  parameter int PIO_NBITS      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_NBITS       = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [PIO_NBITS-1:0] cmd_addr,
  input  logic [PIO_NBITS-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [PIO_NBITS-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 reg_bs,
  output logic                 reg_rd,
  output logic                 reg_wr,
  output logic [PIO_NBITS-1:0] reg_addr,
  output logic [PIO_NBITS-1:0] reg_din,
  input  logic                 pio_ack,
  input  logic                 pio_rvalid,
  input  logic [PIO_NBITS-1:0] pio_rdata
);

  // state     | meaning
  // ST_IDLE   | ready for a host command
  // ST_STROBE | single-cycle reg_rd/reg_wr pulse toward the slave
  // ST_WAIT   | reg_bs held, waiting for slave completion or watchdog
  // ST_RESP   | response held until the host accepts it
  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT, ST_RESP} state_e;

  localparam logic [TO_NBITS-1:0] TO_LAST = TO_NBITS'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 wr_q, wr_d;
  logic                 reg_bs_q, reg_bs_d;
  logic                 reg_rd_q, reg_rd_d;
  logic                 reg_wr_q, reg_wr_d;
  logic [PIO_NBITS-1:0] reg_addr_q, reg_addr_d;
  logic [PIO_NBITS-1:0] reg_din_q, reg_din_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [PIO_NBITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [TO_NBITS-1:0]  to_cnt_q, to_cnt_d;
  logic                 done;

  // A read only completes on rvalid; a stray ack during a read is ignored.
  assign done = wr_q ? pio_ack : pio_rvalid;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    wr_d        = wr_q;
    reg_bs_d    = reg_bs_q;
    reg_rd_d    = 1'b0;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_din_d   = reg_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_STROBE;
          cmd_ready_d = 1'b0;
          wr_d        = cmd_wr;
          reg_bs_d    = 1'b1;
          reg_rd_d    = ~cmd_wr;
          reg_wr_d    = cmd_wr;
          reg_addr_d  = cmd_addr;
          reg_din_d   = cmd_wdata;
        end
      end
      ST_STROBE: begin
        state_d  = ST_WAIT;
        to_cnt_d = '0;
      end
      ST_WAIT: begin
        to_cnt_d = to_cnt_q + TO_NBITS'(1);
        if (done) begin
          state_d     = ST_RESP;
          reg_bs_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = wr_q ? '0 : pio_rdata;
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = ST_RESP;
          reg_bs_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      reg_bs_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wr_q        <= wr_d;
      reg_bs_q    <= reg_bs_d;
      reg_rd_q    <= reg_rd_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_din_q   <= reg_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign reg_bs    = reg_bs_q;
  assign reg_rd    = reg_rd_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_din   = reg_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pio_master.sv
// Bench for pio_master: directed vector table, random transactions against a
// transaction-level model, plus hand-written reset sequences.
module tb_pio_master;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        reg_bs, reg_rd, reg_wr;
  logic [31:0] reg_addr, reg_din;
  logic        pio_ack, pio_rvalid;
  logic [31:0] pio_rdata;

  int nchecks = 0;
  int nerrors = 0;

  pio_master #(.PIO_NBITS(32), .TIMEOUT_CYCLES(T), .TO_NBITS(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .reg_bs(reg_bs), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din),
    .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata)
  );

  always #5 clk = ~clk;

  // d: WAIT-cycle index (0 = first cycle after the strobe) at which the slave answers; -1 = never
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          d;
    bit          stray;
    int          rdy;
    bit          hold;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int idx, input string what, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL t%0d_%s: got %h expected %h", idx, what, act, exp);
    end
  endtask

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                              int d, bit stray, int rdy, bit hold);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.d = d; v.stray = stray; v.rdy = rdy; v.hold = hold;
    return v;
  endfunction

  task automatic run_txn(input int idx, input vec_t v, input vec_t nxt);
    bit          exp_err, seen, bad;
    int          exp_waits, waits;
    logic [31:0] exp_rdata, held_rdata;
    logic        held_err;
    exp_err   = (v.d < 0) || (v.d >= T);
    exp_waits = exp_err ? T : v.d + 1;
    exp_rdata = (v.wr || exp_err) ? 32'h0 : v.rdata;

    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cmd_ready) begin seen = 1'b1; break; end
      tick();
    end
    check(idx, "cmd_ready_wait", 32'(seen), 32'd1);
    if (!seen) begin
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    check(idx, "strobe_bits", {28'h0, reg_bs, reg_rd, reg_wr, cmd_ready}, {28'h0, 1'b1, ~v.wr, v.wr, 1'b0});
    check(idx, "strobe_addr", reg_addr, v.addr);
    if (v.wr) check(idx, "strobe_din", reg_din, v.wdata);

    waits = 0; bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < T + 6; i++) begin
      tick();
      if (rsp_valid) begin seen = 1'b1; break; end
      waits++;
      if (reg_rd || reg_wr || !reg_bs || cmd_ready || reg_addr !== v.addr) bad = 1'b1;
      pio_ack    = (v.wr && i == v.d) || (v.stray && !v.wr && i < v.d);
      pio_rvalid = !v.wr && i == v.d;
      pio_rdata  = (i == v.d) ? v.rdata : $urandom();
    end
    pio_ack = 1'b0; pio_rvalid = 1'b0;
    check(idx, "rsp_seen", 32'(seen), 32'd1);
    check(idx, "wait_cycles", 32'(waits), 32'(exp_waits));
    check(idx, "wait_stable", 32'(bad), 32'd0);
    check(idx, "rsp_err", 32'(rsp_err), 32'(exp_err));
    check(idx, "rsp_rdata", rsp_rdata, exp_rdata);
    check(idx, "resp_bs_rdy", {30'h0, reg_bs, cmd_ready}, 32'h0);

    held_rdata = rsp_rdata; held_err = rsp_err; bad = 1'b0;
    if (v.hold) begin
      cmd_valid = 1'b1; cmd_wr = nxt.wr; cmd_addr = nxt.addr; cmd_wdata = nxt.wdata;
    end
    for (int k = 0; k < v.rdy; k++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== held_rdata || rsp_err !== held_err || cmd_ready || reg_bs) bad = 1'b1;
    end
    if (v.rdy > 0) check(idx, "backpressure", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check(idx, "handshake", {30'h0, rsp_valid, cmd_ready}, 32'h1);

    if (exp_err && !v.hold) begin
      for (int k = 0; k < 4; k++) tick();
      pio_rvalid = 1'b1; pio_ack = 1'b1; pio_rdata = $urandom();
      tick();
      pio_rvalid = 1'b0; pio_ack = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (rsp_valid || reg_bs) bad = 1'b1;
      end
      check(idx, "late_ignored", 32'(bad), 32'd0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit bad;
    vec_t v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0;

    tbl[0] = mk(1'b1, 32'h10, 32'h0000_00AB, 32'h0,         2, 1'b0, 0, 1'b0);
    tbl[1] = mk(1'b0, 32'h10, 32'h0,         32'h0000_00AB, 3, 1'b0, 0, 1'b0);
    tbl[2] = mk(1'b0, 32'h20, 32'h0,         32'h5555_AAAA, -1, 1'b0, 0, 1'b0);
    tbl[3] = mk(1'b0, 32'h24, 32'h0,         32'h1234_5678, 5, 1'b1, 1, 1'b0);
    tbl[4] = mk(1'b0, 32'h28, 32'h0,         32'hCAFE_F00D, T - 1, 1'b1, 0, 1'b0);
    tbl[5] = mk(1'b1, 32'h2C, 32'h0BAD_0BAD, 32'h0,         T, 1'b0, 2, 1'b0);
    tbl[6] = mk(1'b0, 32'h30, 32'h0,         32'h8765_4321, 0, 1'b0, 6, 1'b1);
    tbl[7] = mk(1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0,         1, 1'b0, 0, 1'b0);

    tick(); tick();
    check(0, "rst_ready", 32'(cmd_ready), 32'd0);
    check(0, "rst_strobes", {28'h0, reg_bs, reg_rd, reg_wr, rsp_valid}, 32'h0);
    check(0, "rst_rsp", {rsp_rdata[30:0], rsp_err}, 32'h0);
    check(0, "rst_addr_din", reg_addr | reg_din, 32'h0);
    rst = 1'b0;
    tick();
    check(0, "post_rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_txn(i + 1, tbl[i], (i < 7) ? tbl[i + 1] : tbl[i]);

    for (int r = 0; r < 40; r++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = $urandom();
      v.wdata = $urandom();
      v.rdata = $urandom();
      v.d     = int'($urandom_range(0, T + 1));
      if (v.d == T + 1) v.d = -1;
      v.stray = 1'($urandom_range(0, 1));
      v.rdy   = int'($urandom_range(0, 3));
      v.hold  = 1'b0;
      run_txn(100 + r, v, v);
    end

    // reset while a read is outstanding in WAIT
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h50; cmd_wdata = '0;
    tick();
    cmd_valid = 1'b0;
    check(200, "pre_rst_strobe", {30'h0, reg_bs, reg_rd}, 32'h3);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(200, "mid_rst_outputs", {27'h0, reg_bs, reg_rd, reg_wr, rsp_valid, cmd_ready}, 32'h0);
    tick();
    check(200, "mid_rst_ready", 32'(cmd_ready), 32'd1);
    pio_rvalid = 1'b1; pio_ack = 1'b1; pio_rdata = 32'h1111_2222;
    tick();
    pio_rvalid = 1'b0; pio_ack = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 2 * T; k++) begin
      tick();
      if (rsp_valid || reg_bs) bad = 1'b1;
    end
    check(200, "no_stale_rsp", 32'(bad), 32'd0);

    run_txn(201, mk(1'b0, 32'h60, 32'h0, 32'hA5A5_5A5A, 1, 1'b0, 0, 1'b0),
                 mk(1'b0, 32'h60, 32'h0, 32'hA5A5_5A5A, 1, 1'b0, 0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
